// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: walks each instruction through its state
// sequence, handshakes variable-latency memories and counts retired instructions.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_FETCH    | imem request; load IR and bump PC when imem_ready
// S_DECODE   | classify Op and latch the instruction class
// S_EXEC_R   | ALU on two registers
// S_EXEC_I   | ALU on register and immediate
// S_WB_ALU   | write ALU result back, retire
// S_ADDR     | effective address for LDUR/STUR
// S_MEM_RD   | data memory read, wait for dmem_ready
// S_WB_MEM   | write load data back, retire
// S_MEM_WR   | data memory write, retire on dmem_ready
// S_BRANCH   | evaluate branch, retire
// S_ILLEGAL  | undecodable opcode, terminal until reset
// S_FAULT    | memory wait timeout, terminal until reset
module multicycle_ctrl #(
  parameter int OP_W     = 11,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  Op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             pc_write,
  output logic             ir_write,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_ILLEGAL, S_FAULT
  } state_t;

  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LD, C_ST, C_BR} cls_t;

  localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

  state_t state, state_nxt;
  cls_t cls_q, dec_cls;
  logic [WC_W-1:0] wait_cnt;
  logic wait_hit, waiting;

  logic imem_req_c, pc_write_c, ir_write_c, reg2loc_c, alusrc_c, memtoreg_c;
  logic regwrite_c, memread_c, memwrite_c, branch_c, done_c;
  logic [1:0] aluop_c;

  always_comb begin
    dec_cls = C_NONE;
    casez (Op)
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b10101011000, 11'b11101011000: dec_cls = C_R;
      11'b1001000100?, 11'b1101000100?,
      11'b1011000100?, 11'b1111000100?:                   dec_cls = C_I;
      11'b11111000010:                                    dec_cls = C_LD;
      11'b11111000000:                                    dec_cls = C_ST;
      11'b10110100???, 11'b01010100???:                   dec_cls = C_BR;
      default:                                            dec_cls = C_NONE;
    endcase
  end

  // Ready landing on the same cycle the counter hits the limit still wins.
  assign wait_hit = (WAIT_MAX != 0) && (wait_cnt == WAIT_LIM);
  assign waiting  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  always_comb begin
    state_nxt  = state;
    imem_req_c = 1'b0;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    reg2loc_c  = 1'b0;
    alusrc_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    branch_c   = 1'b0;
    done_c     = 1'b0;
    aluop_c    = 2'b00;
    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end else if (wait_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_R:        state_nxt = S_EXEC_R;
          C_I:        state_nxt = S_EXEC_I;
          C_LD, C_ST: state_nxt = S_ADDR;
          C_BR:       state_nxt = S_BRANCH;
          default:    state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        aluop_c   = 2'b10;
        state_nxt = S_WB_ALU;
      end
      S_EXEC_I: begin
        alusrc_c  = 1'b1;
        aluop_c   = 2'b11;
        state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        regwrite_c = 1'b1;
        alusrc_c   = (cls_q == C_I);
        aluop_c    = (cls_q == C_I) ? 2'b11 : 2'b10;
        done_c     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADDR: begin
        alusrc_c  = 1'b1;
        state_nxt = (cls_q == C_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        memread_c = 1'b1;
        alusrc_c  = 1'b1;
        if (dmem_ready)    state_nxt = S_WB_MEM;
        else if (wait_hit) state_nxt = S_FAULT;
      end
      S_WB_MEM: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        done_c     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        memwrite_c = 1'b1;
        reg2loc_c  = 1'b1;
        alusrc_c   = 1'b1;
        if (dmem_ready) begin
          done_c    = 1'b1;
          state_nxt = S_FETCH;
        end else if (wait_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_BRANCH: begin
        reg2loc_c = 1'b1;
        branch_c  = 1'b1;
        aluop_c   = 2'b01;
        done_c    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      S_FAULT:   state_nxt = S_FAULT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      cls_q       <= C_NONE;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting && (wait_cnt != WAIT_LIM))
        wait_cnt <= wait_cnt + WC_W'(1);
      if (state == S_DECODE)
        cls_q <= dec_cls;
      if (done_c)
        instr_count <= instr_count + CNT_W'(1);
      if (state_nxt == S_ILLEGAL)
        illegal <= 1'b1;
      if (state_nxt == S_FAULT)
        fault <= 1'b1;
    end
  end

  // State resets to FETCH asynchronously, so the strobes are masked while reset is high.
  assign imem_req   = imem_req_c & ~reset;
  assign pc_write   = pc_write_c & ~reset;
  assign ir_write   = ir_write_c & ~reset;
  assign Reg2Loc    = reg2loc_c  & ~reset;
  assign ALUSrc     = alusrc_c   & ~reset;
  assign MemtoReg   = memtoreg_c & ~reset;
  assign RegWrite   = regwrite_c & ~reset;
  assign MemRead    = memread_c  & ~reset;
  assign MemWrite   = memwrite_c & ~reset;
  assign Branch     = branch_c   & ~reset;
  assign ALUOp      = aluop_c & {2{~reset}};
  assign instr_done = done_c     & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences with a retire scoreboard
// plus per-cycle control-line checks.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] Op = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, pc_write, ir_write, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, instr_done, illegal, fault;
  logic [1:0]  ALUOp;
  logic [31:0] instr_count;

  multicycle_ctrl #(.OP_W(11), .WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .pc_write(pc_write), .ir_write(ir_write), .Reg2Loc(Reg2Loc),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .instr_done(instr_done),
    .instr_count(instr_count), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  // {imem_req,pc_write,ir_write}_{Reg2Loc,ALUSrc,MemtoReg,RegWrite}_{MemRead,MemWrite,Branch}_ALUOp_instr_done
  logic [12:0] ctl;
  assign ctl = {imem_req, pc_write, ir_write, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, ALUOp, instr_done};

  localparam logic [12:0] CTL_FETCH = 13'b111_0000_000_00_0;
  localparam logic [12:0] CTL_ADD   = 13'b000_0001_000_10_1;
  localparam logic [12:0] CTL_ADDI  = 13'b000_0101_000_11_1;
  localparam logic [12:0] CTL_LDUR  = 13'b000_0011_000_00_1;
  localparam logic [12:0] CTL_STUR  = 13'b000_1100_010_00_1;
  localparam logic [12:0] CTL_CBZ   = 13'b000_1000_001_01_1;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_ADDI  = 11'b10010001001;
  localparam logic [10:0] OP_SUBIS = 11'b11110001000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100101;
  localparam logic [10:0] OP_BCOND = 11'b01010100011;
  localparam logic [10:0] OP_BAD   = 11'b00000000000;

  typedef struct {
    int          lat;
    logic [12:0] ctl;
    logic [31:0] cnt;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  int          cyc_n = 0;
  logic        cnt_pend = 1'b0;
  logic [31:0] cnt_exp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int lat, input logic [12:0] c);
    rec_t r;
    exp_cnt++;
    r.lat = lat;
    r.ctl = c;
    r.cnt = 32'(exp_cnt);
    sb.push_back(r);
  endtask

  task automatic cyc(input logic im, input logic dm);
    imem_ready = im;
    dmem_ready = dm;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    Op = OP_ADD;
    #1;
    chk("reset_ctl", ctl, 0);
    chk("reset_flags", {illegal, fault}, 0);
    chk("reset_count", instr_count, 0);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic fast(input logic [10:0] op, input int lat, input logic [12:0] c);
    push(lat, c);
    Op = op;
    repeat (lat) begin
      cyc(1'b1, 1'b1);
      adv();
    end
  endtask

  // Retire monitor: latency since fetch start, control lines at retire, count afterwards.
  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      cyc_n = 0;
      cnt_pend = 1'b0;
    end else begin
      cyc_n++;
      if (cnt_pend) begin
        chk("retire_count", instr_count, cnt_exp);
        cnt_pend = 1'b0;
      end
      if (instr_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual=instr_done expected=none t=%0t", $time);
        end else begin
          r = sb.pop_front();
          chk("retire_latency", 64'(cyc_n), 64'(r.lat));
          chk("retire_ctl", ctl, r.ctl);
          cnt_exp  = r.cnt;
          cnt_pend = 1'b1;
        end
        cyc_n = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // ADD cycle by cycle
    push(4, CTL_ADD);
    Op = OP_ADD;
    cyc(1, 0); chk("add_fetch", ctl, CTL_FETCH); adv();
    cyc(1, 0); chk("add_decode", ctl, 0); adv();
    cyc(1, 0); chk("add_exec", ctl, 13'b000_0000_000_10_0); adv();
    cyc(1, 0); chk("add_wb_regwrite", RegWrite, 1); adv();

    fast(OP_ADDI, 4, CTL_ADDI);
    fast(OP_SUBS, 4, CTL_ADD);
    fast(OP_SUBIS, 4, CTL_ADDI);
    fast(OP_BCOND, 3, CTL_CBZ);
    fast(OP_LDUR, 5, CTL_LDUR);

    // LDUR with three dmem wait cycles
    push(8, CTL_LDUR);
    Op = OP_LDUR;
    cyc(1, 0); adv();
    cyc(1, 0); adv();
    cyc(1, 0); chk("ldur_addr", ctl, 13'b000_0100_000_00_0); adv();
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 3));
      chk("ldur_memread", ctl, 13'b000_0100_100_00_0);
      adv();
    end
    cyc(1, 0); adv();

    // STUR then CBZ back to back from reset
    do_reset();
    push(4, CTL_STUR);
    Op = OP_STUR;
    repeat (4) begin cyc(1, 1); adv(); end
    push(3, CTL_CBZ);
    Op = OP_CBZ;
    repeat (3) begin cyc(1, 1); adv(); end
    cyc(0, 0); chk("stur_cbz_count", instr_count, 2);

    // illegal opcode
    do_reset();
    Op = OP_BAD;
    cyc(1, 0); adv();
    cyc(1, 0); chk("illegal_in_decode", illegal, 0); adv();
    cyc(1, 0); chk("illegal_set", illegal, 1); adv();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1);
      chk("illegal_quiet", {ctl, illegal}, {13'b0, 1'b1});
      adv();
    end
    chk("illegal_count", instr_count, 0);

    // imem timeout
    do_reset();
    Op = OP_ADD;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0);
      chk("fetch_wait", {imem_req, fault}, 2'b10);
      adv();
    end
    cyc(1, 1); chk("fetch_timeout", {ctl, fault}, {13'b0, 1'b1}); adv();
    repeat (3) begin
      cyc(1, 1); chk("fault_sticky", {ctl, fault}, {13'b0, 1'b1}); adv();
    end

    // imem ready exactly at the limit
    do_reset();
    Op = OP_ADD;
    push(19, CTL_ADD);
    for (int i = 0; i < 15; i++) begin cyc(0, 0); adv(); end
    cyc(1, 0); chk("late_ready_fetch", ctl, CTL_FETCH); adv();
    cyc(1, 0); chk("late_ready_decode", {ctl, fault}, 0); adv();
    cyc(1, 0); adv();
    cyc(1, 0); adv();
    cyc(0, 0); chk("late_ready_nofault", fault, 0); adv();

    // dmem timeout on a load
    do_reset();
    Op = OP_LDUR;
    repeat (3) begin cyc(1, 0); adv(); end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0);
      chk("memrd_wait", {MemRead, fault}, 2'b10);
      adv();
    end
    cyc(1, 1); chk("memrd_timeout", {ctl, fault}, {13'b0, 1'b1}); adv();

    // reset while a store is waiting
    do_reset();
    Op = OP_STUR;
    repeat (3) begin cyc(1, 0); adv(); end
    cyc(1, 0); chk("memwr_active", ctl, 13'b000_1100_010_00_0); adv();
    cyc(1, 0);
    #1 reset = 1'b1;
    #1 chk("memwr_reset_ctl", ctl, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0);
    chk("post_reset_imem_req", imem_req, 1);
    chk("post_reset_count", instr_count, 0);
    adv();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle LEGv8 main decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the datapath control lines state by state.
- Handshakes with instruction and data memories that have variable latency, with a wait-timeout fault.
- Flags illegal opcodes and counts retired instructions.
- Sits between the IR/PC/register-file/ALU datapath and the memory ports.

Parameters:
OP_W, 11, opcode field width taken from IR[31:21]
WAIT_MAX, 15, maximum cycles spent waiting on imem_ready/dmem_ready before entering FAULT; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
Op  in  OP_W  opcode from IR; valid only in DECODE
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
pc_write  out  1  PC <= PC+4 enable
ir_write  out  1  IR load enable
Reg2Loc  out  1  register read-2 select
ALUSrc  out  1  ALU B from immediate
MemtoReg  out  1  write-back from memory
RegWrite  out  1  register file write
MemRead  out  1  data memory read request
MemWrite  out  1  data memory write request
Branch  out  1  branch evaluate/take enable
ALUOp  out  2  00 add, 01 branch, 10 R-type, 11 I-type
instr_done  out  1  one-cycle pulse when an instruction retires
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
illegal  out  1  sticky: undecodable opcode seen
fault  out  1  sticky: memory wait timeout

Behaviour:
- Reset (async, high): state=FETCH, wait counter=0, class register=0, instr_count=0, illegal=0, fault=0. Every output is 0 while reset is high, including imem_req.
- Outputs are Moore from state, except pc_write, ir_write, instr_done and the dmem completion, which also qualify on ready. Any control line not listed for a state is 0.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: all control lines 0. Classify Op and latch the class:
  - R-type: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 10101011000 ADDS, 11101011000 SUBS -> EXEC_R.
  - I-type: 1001000100? ADDI, 1101000100? SUBI, 1011000100? ADDIS, 1111000100? SUBIS -> EXEC_I.
  - 11111000010 LDUR, 11111000000 STUR -> ADDR.
  - 10110100??? CBZ, 01010100??? B.cond -> BRANCH.
  - Anything else -> ILLEGAL.
- EXEC_R: ALUOp=10 -> WB_ALU.
- EXEC_I: ALUSrc=1, ALUOp=11 -> WB_ALU.
- WB_ALU:
  - RegWrite=1.
  - ALUSrc/ALUOp held from the latched class.
  - instr_done=1 -> FETCH.
- ADDR: ALUSrc=1, ALUOp=00 -> MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD:
  - MemRead=1, ALUSrc=1, held until dmem_ready.
  - On dmem_ready -> WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1, instr_done=1 -> FETCH.
- MEM_WR:
  - MemWrite=1, Reg2Loc=1, ALUSrc=1, held until dmem_ready.
  - On the dmem_ready cycle: instr_done=1 -> FETCH.
- BRANCH: Reg2Loc=1, Branch=1, ALUOp=01, instr_done=1 -> FETCH.
- ILLEGAL:
  - illegal=1, terminal until reset.
  - No further imem_req. instr_count is not incremented.
- FAULT:
  - fault=1, terminal until reset. All control lines 0.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle the corresponding ready input is 0.
  - If WAIT_MAX!=0 and the counter reaches WAIT_MAX with ready still 0, the next state is FAULT.
  - Ready arriving in the same cycle the counter reaches WAIT_MAX wins: normal transition, no fault.
- instr_count increments by 1 on every instr_done and wraps from all-ones to 0.
- Latency with zero-wait memories:
  - R/I-type 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDUR 5 cycles (FETCH, DECODE, ADDR, MEM_RD, WB_MEM).
  - STUR 4 cycles.
  - CBZ/B.cond 3 cycles.
- ready inputs are ignored outside their wait states.
- Reset asserted mid-instruction aborts immediately: no partial RegWrite/MemWrite after reset rises.

Test Plan:
- ADD (Op=10001011000), imem_ready=1 always -> ir_write/pc_write pulse in cycle 0; ALUOp=10 in cycle 2; RegWrite=1 in cycle 3; instr_done in cycle 3; instr_count=1.
- LDUR (11111000010), dmem_ready low for 3 cycles -> MemRead high for 4 cycles, then RegWrite=MemtoReg=1 for one cycle; 8 cycles total.
- STUR then CBZ (10110100101) back-to-back -> MemWrite=1 with Reg2Loc=1; then Branch=1 with ALUOp=01 for one cycle; instr_count=2 after 7 cycles.
- Op=00000000000 -> illegal=1 from the cycle after DECODE; imem_req stays 0 for 20 cycles; clears only on reset.
- WAIT_MAX=15, imem_ready held 0 -> fault=1 after 15 wait cycles. Repeat with ready arriving exactly in cycle 15 -> no fault, DECODE entered.
- Assert reset during MEM_WR with MemWrite=1 -> all outputs 0 that cycle; after release, imem_req=1 and instr_count=0.
